enable_burst_sequencer: RTL and testbench

ENABLE_BURST_SEQUENCER -- requirements
Module: enable_burst_sequencer

---
 rtl/enable_seq_pkg.sv | 33 +++
 rtl/enable_burst_sequencer_if.sv | 62 ++++++
 rtl/enable_seq_beat_cnt.sv | 69 ++++++
 rtl/enable_burst_sequencer.sv | 166 ++++++++++++++++
 tb/tb_enable_burst_sequencer.sv | 214 +++++++++++++++++++++
 5 files changed

// File: rtl/enable_seq_pkg.sv
// Shared types and constants for the enable burst sequencer.
//   seq_state_e : sequencer FSM states, in traversal order
//   RESP_OKAY, BURST_INCR, SIZE_4B : fixed AXI encodings used by the sequencer
//   sat_add     : 8-bit saturating add used by the error counter
package enable_seq_pkg;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned CNT_W  = 8;
    localparam int unsigned ERR_W  = 8;

    localparam logic [1:0] RESP_OKAY  = 2'b00;
    localparam logic [1:0] BURST_INCR = 2'b01;
    localparam logic [2:0] SIZE_4B    = 3'b010;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        AW   = 3'd1,
        W    = 3'd2,
        B    = 3'd3,
        AR   = 3'd4,
        R    = 3'd5,
        DONE = 3'd6
    } seq_state_e;

    // Error counter add that sticks at all-ones instead of wrapping.
    function automatic logic [ERR_W-1:0] sat_add(input logic [ERR_W-1:0] a, input logic [1:0] b);
        logic [ERR_W:0] s;
        s = {1'b0, a} + (ERR_W+1)'(b);
        return s[ERR_W] ? {ERR_W{1'b1}} : s[ERR_W-1:0];
    endfunction

endpackage

// File: rtl/enable_burst_sequencer_if.sv
// AXI4 write/read channel bundle between the sequencer (master) and a memory slave.
//   AW/W/B : write address, write data, write response
//   AR/R   : read address, read data
interface enable_burst_sequencer_if;

    logic [31:0] M_AXI_AWADDR;
    logic [7:0]  M_AXI_AWLEN;
    logic [2:0]  M_AXI_AWSIZE;
    logic [1:0]  M_AXI_AWBURST;
    logic        M_AXI_AWVALID;
    logic        M_AXI_AWREADY;

    logic [31:0] M_AXI_WDATA;
    logic [3:0]  M_AXI_WSTRB;
    logic        M_AXI_WLAST;
    logic        M_AXI_WVALID;
    logic        M_AXI_WREADY;

    logic [1:0]  M_AXI_BRESP;
    logic        M_AXI_BVALID;
    logic        M_AXI_BREADY;

    logic [31:0] M_AXI_ARADDR;
    logic [7:0]  M_AXI_ARLEN;
    logic [2:0]  M_AXI_ARSIZE;
    logic [1:0]  M_AXI_ARBURST;
    logic        M_AXI_ARVALID;
    logic        M_AXI_ARREADY;

    logic [31:0] M_AXI_RDATA;
    logic [1:0]  M_AXI_RRESP;
    logic        M_AXI_RLAST;
    logic        M_AXI_RVALID;
    logic        M_AXI_RREADY;

    modport master (
        output M_AXI_AWADDR, M_AXI_AWLEN, M_AXI_AWSIZE, M_AXI_AWBURST, M_AXI_AWVALID,
        input  M_AXI_AWREADY,
        output M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WLAST, M_AXI_WVALID,
        input  M_AXI_WREADY,
        input  M_AXI_BRESP, M_AXI_BVALID,
        output M_AXI_BREADY,
        output M_AXI_ARADDR, M_AXI_ARLEN, M_AXI_ARSIZE, M_AXI_ARBURST, M_AXI_ARVALID,
        input  M_AXI_ARREADY,
        input  M_AXI_RDATA, M_AXI_RRESP, M_AXI_RLAST, M_AXI_RVALID,
        output M_AXI_RREADY
    );

    modport slave (
        input  M_AXI_AWADDR, M_AXI_AWLEN, M_AXI_AWSIZE, M_AXI_AWBURST, M_AXI_AWVALID,
        output M_AXI_AWREADY,
        input  M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WLAST, M_AXI_WVALID,
        output M_AXI_WREADY,
        output M_AXI_BRESP, M_AXI_BVALID,
        input  M_AXI_BREADY,
        input  M_AXI_ARADDR, M_AXI_ARLEN, M_AXI_ARSIZE, M_AXI_ARBURST, M_AXI_ARVALID,
        output M_AXI_ARREADY,
        output M_AXI_RDATA, M_AXI_RRESP, M_AXI_RLAST, M_AXI_RVALID,
        input  M_AXI_RREADY
    );

endinterface

// File: rtl/enable_seq_beat_cnt.sv
// Beat counter and test-pattern generator shared by the write and read bursts.
//   clr   : hold the counter at beat 0 (used outside the W and R phases)
//   adv   : advance one beat (a W or R handshake)
//   value : pattern for the current beat, i+1
//   last  : current beat is BURST_LEN-1
//   early : current beat is before BURST_LEN-1
module enable_seq_beat_cnt
    import enable_seq_pkg::*;
#(
    parameter int unsigned BURST_LEN = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              adv,
    output logic [DATA_W-1:0] value,
    output logic              last,
    output logic              early
);

    localparam logic [CNT_W-1:0] LAST_IDX  = CNT_W'(BURST_LEN - 1);
    localparam logic             LAST_INIT = (BURST_LEN == 1);

    logic [CNT_W-1:0]  cnt_q,   cnt_d;
    logic [DATA_W-1:0] value_q, value_d;
    logic              last_q,  last_d;
    logic              early_q, early_d;

    // Flags are computed from the next count so they are registered with it.
    always_comb begin
        cnt_d   = cnt_q;
        value_d = value_q;
        last_d  = last_q;
        early_d = early_q;
        if (clr) begin
            cnt_d   = '0;
            value_d = DATA_W'(1);
            last_d  = LAST_INIT;
            early_d = !LAST_INIT;
        end else if (adv) begin
            // Count sticks at all-ones so an overlong read burst never re-hits LAST_IDX.
            if (cnt_q != '1) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
            value_d = value_q + DATA_W'(1);
            last_d  = (cnt_d == LAST_IDX);
            early_d = (cnt_d < LAST_IDX);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            value_q <= DATA_W'(1);
            last_q  <= LAST_INIT;
            early_q <= !LAST_INIT;
        end else begin
            cnt_q   <= cnt_d;
            value_q <= value_d;
            last_q  <= last_d;
            early_q <= early_d;
        end
    end

    assign value = value_q;
    assign last  = last_q;
    assign early = early_q;

endmodule

// File: rtl/enable_burst_sequencer.sv
// Writes an incrementing pattern burst to BASE_ADDR, reads it back and counts errors.
//   ACLK, ARESETN : clock, asynchronous active-low reset
//   start         : request a write-then-readback sequence (accepted only when idle)
//   busy, done    : sequence in progress / one-cycle completion pulse
//   pass, fail_cnt: result of the last sequence (held until the next start)
//   axi           : AXI4 master channels
module enable_burst_sequencer
    import enable_seq_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0,
    parameter int unsigned BURST_LEN = 8
) (
    input  logic                      ACLK,
    input  logic                      ARESETN,
    input  logic                      start,
    output logic                      busy,
    output logic                      done,
    output logic                      pass,
    output logic [7:0]                fail_cnt,
    enable_burst_sequencer_if.master  axi
);

    seq_state_e        state_q, state_d;
    logic              awvalid_q, awvalid_d;
    logic              wvalid_q,  wvalid_d;
    logic              bready_q,  bready_d;
    logic              arvalid_q, arvalid_d;
    logic              rready_q,  rready_d;
    logic              busy_q,    busy_d;
    logic              done_q,    done_d;
    logic              pass_q,    pass_d;
    logic [ERR_W-1:0]  fail_q,    fail_d;
    logic [1:0]        r_err;

    logic [DATA_W-1:0] beat_value;
    logic              beat_last;
    logic              beat_early;

    logic aw_hs, w_hs, b_hs, ar_hs, r_hs;

    assign aw_hs = awvalid_q & axi.M_AXI_AWREADY;
    assign w_hs  = wvalid_q  & axi.M_AXI_WREADY;
    assign b_hs  = bready_q  & axi.M_AXI_BVALID;
    assign ar_hs = arvalid_q & axi.M_AXI_ARREADY;
    assign r_hs  = rready_q  & axi.M_AXI_RVALID;

    // One counter serves both bursts; it is parked at beat 0 outside W and R.
    enable_seq_beat_cnt #(.BURST_LEN(BURST_LEN)) u_beat_cnt (
        .clk   (ACLK),
        .rst_n (ARESETN),
        .clr   ((state_q != W) && (state_q != R)),
        .adv   (((state_q == W) && w_hs) || ((state_q == R) && r_hs)),
        .value (beat_value),
        .last  (beat_last),
        .early (beat_early)
    );

    // Next-state, error accounting and registered channel controls.
    always_comb begin
        state_d = state_q;
        fail_d  = fail_q;
        pass_d  = pass_q;
        r_err   = 2'd0;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = AW;
                    fail_d  = '0;
                    pass_d  = 1'b0;
                end
            end
            AW: if (aw_hs) state_d = W;
            W:  if (w_hs && beat_last) state_d = B;
            B: begin
                if (b_hs) begin
                    if (axi.M_AXI_BRESP != RESP_OKAY) begin
                        fail_d = sat_add(fail_q, 2'd1);
                    end
                    state_d = AR;
                end
            end
            AR: if (ar_hs) state_d = R;
            R: begin
                if (r_hs) begin
                    // Data/response error, early RLAST and missing RLAST are counted separately.
                    if ((axi.M_AXI_RDATA != beat_value) || (axi.M_AXI_RRESP != RESP_OKAY)) begin
                        r_err = r_err + 2'd1;
                    end
                    if (axi.M_AXI_RLAST && beat_early) begin
                        r_err = r_err + 2'd1;
                    end
                    if (!axi.M_AXI_RLAST && beat_last) begin
                        r_err = r_err + 2'd1;
                    end
                    fail_d = sat_add(fail_q, r_err);
                    if (axi.M_AXI_RLAST) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase

        awvalid_d = (state_d == AW);
        wvalid_d  = (state_d == W);
        bready_d  = (state_d == B);
        arvalid_d = (state_d == AR);
        rready_d  = (state_d == R);
        busy_d    = (state_d != IDLE) && (state_d != DONE);
        done_d    = (state_d == DONE);
        if (state_d == DONE) begin
            pass_d = (fail_d == '0);
        end
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state_q   <= IDLE;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            bready_q  <= 1'b0;
            arvalid_q <= 1'b0;
            rready_q  <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            pass_q    <= 1'b0;
            fail_q    <= '0;
        end else begin
            state_q   <= state_d;
            awvalid_q <= awvalid_d;
            wvalid_q  <= wvalid_d;
            bready_q  <= bready_d;
            arvalid_q <= arvalid_d;
            rready_q  <= rready_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            pass_q    <= pass_d;
            fail_q    <= fail_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign pass     = pass_q;
    assign fail_cnt = fail_q;

    assign axi.M_AXI_AWADDR  = BASE_ADDR;
    assign axi.M_AXI_AWLEN   = 8'(BURST_LEN - 1);
    assign axi.M_AXI_AWSIZE  = SIZE_4B;
    assign axi.M_AXI_AWBURST = BURST_INCR;
    assign axi.M_AXI_AWVALID = awvalid_q;
    assign axi.M_AXI_WDATA   = beat_value;
    assign axi.M_AXI_WSTRB   = 4'hF;
    assign axi.M_AXI_WLAST   = beat_last;
    assign axi.M_AXI_WVALID  = wvalid_q;
    assign axi.M_AXI_BREADY  = bready_q;
    assign axi.M_AXI_ARADDR  = BASE_ADDR;
    assign axi.M_AXI_ARLEN   = 8'(BURST_LEN - 1);
    assign axi.M_AXI_ARSIZE  = SIZE_4B;
    assign axi.M_AXI_ARBURST = BURST_INCR;
    assign axi.M_AXI_ARVALID = arvalid_q;
    assign axi.M_AXI_RREADY  = rready_q;

endmodule

// File: tb/tb_enable_burst_sequencer.sv
// Directed bench: a procedural AXI slave answers the sequencer cycle by cycle.
module tb_enable_burst_sequencer;

    localparam logic [31:0] BASE = 32'h4000_1000;
    localparam int          LEN  = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       busy, done, pass;
    logic [7:0] fail_cnt;

    int n_assert = 0;
    int n_fail   = 0;

    enable_burst_sequencer_if axi();

    enable_burst_sequencer #(.BASE_ADDR(BASE), .BURST_LEN(LEN)) dut (
        .ACLK     (clk),
        .ARESETN  (rst_n),
        .start    (start),
        .busy     (busy),
        .done     (done),
        .pass     (pass),
        .fail_cnt (fail_cnt),
        .axi      (axi)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clr_slave();
        axi.M_AXI_AWREADY = 1'b0;
        axi.M_AXI_WREADY  = 1'b0;
        axi.M_AXI_BVALID  = 1'b0;
        axi.M_AXI_BRESP   = 2'b00;
        axi.M_AXI_ARREADY = 1'b0;
        axi.M_AXI_RVALID  = 1'b0;
        axi.M_AXI_RDATA   = 32'h0;
        axi.M_AXI_RRESP   = 2'b00;
        axi.M_AXI_RLAST   = 1'b0;
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_awvalid"}, 32'(axi.M_AXI_AWVALID), 32'd0);
        chk({tag, "_wvalid"},  32'(axi.M_AXI_WVALID),  32'd0);
        chk({tag, "_bready"},  32'(axi.M_AXI_BREADY),  32'd0);
        chk({tag, "_arvalid"}, 32'(axi.M_AXI_ARVALID), 32'd0);
        chk({tag, "_rready"},  32'(axi.M_AXI_RREADY),  32'd0);
        chk({tag, "_busy"},    32'(busy),              32'd0);
        chk({tag, "_done"},    32'(done),              32'd0);
        chk({tag, "_pass"},    32'(pass),              32'd0);
        chk({tag, "_failcnt"}, 32'(fail_cnt),          32'd0);
    endtask

    // One full sequence; slave inputs are decided at each negedge for the next posedge.
    task automatic run_seq(input bit bp, input logic [1:0] bresp, input int corrupt_mask,
                           input int rlast_idx, input int restart_at, input int reset_at_w,
                           input int exp_fail, input int exp_rbeats);
        int  w_beats  = 0;
        int  r_sent   = 0;
        bit  b_sent   = 0;
        bit  ar_done  = 0;
        bit  aw_hold  = 0;
        bit  w_hold   = 0;
        bit  ar_hold  = 0;
        bit  finished = 0;

        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        chk("start_busy",    32'(busy),              32'd1);
        chk("start_awvalid", 32'(axi.M_AXI_AWVALID), 32'd1);
        chk("start_failcnt", 32'(fail_cnt),          32'd0);
        chk("start_pass",    32'(pass),              32'd0);
        chk("awaddr",  axi.M_AXI_AWADDR,           BASE);
        chk("awlen",   32'(axi.M_AXI_AWLEN),       32'(LEN - 1));
        chk("awsize",  32'(axi.M_AXI_AWSIZE),      32'd2);
        chk("awburst", 32'(axi.M_AXI_AWBURST),     32'd1);
        chk("wstrb",   32'(axi.M_AXI_WSTRB),       32'hF);

        for (int cyc = 0; cyc < 400; cyc++) begin
            if (done === 1'b1) begin
                finished = 1;
                break;
            end
            start = (cyc == restart_at);

            // Write address
            if (aw_hold) chk("aw_held", 32'(axi.M_AXI_AWVALID), 32'd1);
            if (axi.M_AXI_AWVALID) begin
                axi.M_AXI_AWREADY = bp ? 1'($urandom_range(0, 1)) : 1'b1;
                aw_hold = !axi.M_AXI_AWREADY;
            end else begin
                axi.M_AXI_AWREADY = 1'b0;
                aw_hold = 0;
            end

            // Write response, offered only after the last write beat has been accepted
            if (!b_sent && w_beats == LEN) begin
                axi.M_AXI_BVALID = 1'b1;
                axi.M_AXI_BRESP  = bresp;
                if (axi.M_AXI_BREADY) b_sent = 1;
            end else begin
                axi.M_AXI_BVALID = 1'b0;
            end

            // Write data
            if (w_hold) chk("w_held", 32'(axi.M_AXI_WVALID), 32'd1);
            if (axi.M_AXI_WVALID) begin
                if (reset_at_w == w_beats) begin
                    rst_n = 1'b0;
                    #1;
                    chk_idle_outputs("rst_mid");
                    start = 1'b0;
                    clr_slave();
                    return;
                end
                chk("wdata", axi.M_AXI_WDATA, 32'(w_beats + 1));
                chk("wlast", 32'(axi.M_AXI_WLAST), 32'(w_beats == LEN - 1));
                axi.M_AXI_WREADY = bp ? 1'($urandom_range(0, 1)) : 1'b1;
                if (axi.M_AXI_WREADY) w_beats++;
                w_hold = !axi.M_AXI_WREADY;
            end else begin
                axi.M_AXI_WREADY = 1'b0;
                w_hold = 0;
            end

            // Read data, starting the cycle after the AR handshake
            if (ar_done && r_sent <= rlast_idx) begin
                axi.M_AXI_RVALID = 1'b1;
                axi.M_AXI_RDATA  = 32'(r_sent + 1) ^ (corrupt_mask[r_sent] ? 32'h0000_0100 : 32'h0);
                axi.M_AXI_RRESP  = 2'b00;
                axi.M_AXI_RLAST  = (r_sent == rlast_idx);
                if (axi.M_AXI_RREADY) r_sent++;
            end else begin
                axi.M_AXI_RVALID = 1'b0;
                axi.M_AXI_RLAST  = 1'b0;
            end

            // Read address
            if (ar_hold) chk("ar_held", 32'(axi.M_AXI_ARVALID), 32'd1);
            if (axi.M_AXI_ARVALID) begin
                axi.M_AXI_ARREADY = bp ? 1'($urandom_range(0, 1)) : 1'b1;
                if (axi.M_AXI_ARREADY) ar_done = 1;
                ar_hold = !axi.M_AXI_ARREADY;
            end else begin
                axi.M_AXI_ARREADY = 1'b0;
                ar_hold = 0;
            end

            @(negedge clk);
        end
        start = 1'b0;
        clr_slave();

        chk("seq_timeout",  32'(finished),     32'd1);
        chk("done_pulse",   32'(done),         32'd1);
        chk("done_busy",    32'(busy),         32'd0);
        chk("done_pass",    32'(pass),         32'(exp_fail == 0));
        chk("done_failcnt", 32'(fail_cnt),     32'(exp_fail));
        chk("w_beats",      32'(w_beats),      32'(LEN));
        chk("b_sent",       32'(b_sent),       32'd1);
        chk("r_beats",      32'(r_sent),       32'(exp_rbeats));
        @(negedge clk);
        chk("after_done",    32'(done),     32'd0);
        chk("hold_pass",     32'(pass),     32'(exp_fail == 0));
        chk("hold_failcnt",  32'(fail_cnt), 32'(exp_fail));
        repeat (3) @(negedge clk);
        chk("no_queued_start", 32'(busy), 32'd0);
        chk("idle_awvalid",    32'(axi.M_AXI_AWVALID), 32'd0);
    endtask

    initial begin
        clr_slave();

        // Reset state
        @(negedge clk);
        chk_idle_outputs("in_reset");
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk_idle_outputs("post_reset");
        chk("araddr", axi.M_AXI_ARADDR,       BASE);
        chk("arlen",  32'(axi.M_AXI_ARLEN),   32'(LEN - 1));

        // Clean zero-wait run
        run_seq(1'b0, 2'b00, 0, LEN - 1, -1, -1, 0, LEN);
        // Random backpressure on AW/W/AR
        run_seq(1'b1, 2'b00, 0, LEN - 1, -1, -1, 0, LEN);
        // Read beats 2 and 5 corrupted
        run_seq(1'b0, 2'b00, (1 << 2) | (1 << 5), LEN - 1, -1, -1, 2, LEN);
        // SLVERR write response, clean readback
        run_seq(1'b0, 2'b10, 0, LEN - 1, -1, -1, 1, LEN);
        // Early RLAST on beat 3, plus a start pulse while busy
        run_seq(1'b0, 2'b00, 0, 3, 5, -1, 1, 4);
        // Reset during write beat 4, then a clean run
        run_seq(1'b0, 2'b00, 0, LEN - 1, -1, 4, 0, LEN);
        repeat (2) @(negedge clk);
        chk_idle_outputs("held_reset");
        rst_n = 1'b1;
        @(negedge clk);
        run_seq(1'b0, 2'b00, 0, LEN - 1, -1, -1, 0, LEN);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
